// File: rtl/stack_machine_pkg.sv
// Shared opcode and FSM state encodings for the expression stack machine.
// The compiler/loader uses the same opcode values.
package stack_machine_pkg;

    typedef enum logic [2:0] {
        OpPushImm = 3'd0,
        OpPushX   = 3'd1,
        OpAdd     = 3'd2,
        OpSub     = 3'd3,
        OpMul     = 3'd4,
        OpNeg     = 3'd5,
        OpEnd     = 3'd6,
        OpRsvd    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StError
    } state_e;

    function automatic logic is_push(input opcode_e op);
        return (op == OpPushImm) || (op == OpPushX);
    endfunction

    function automatic logic is_binary(input opcode_e op);
        return (op == OpAdd) || (op == OpSub) || (op == OpMul);
    endfunction

endpackage

// File: rtl/stack_machine_alu.sv
// Combinational ALU: wrapping add/sub/negate and a signed fixed-point multiply.
// For binary ops the result is nos op tos.
module stack_machine_alu
    import stack_machine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  opcode_e               op,
    input  logic [DATA_WIDTH-1:0] nos,
    input  logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] result
);

    logic signed [2*DATA_WIDTH-1:0] product;

    // Sign-extended operands give the exact signed product in 2*DATA_WIDTH bits.
    // The arithmetic shift then truncates toward -inf.
    assign product = {{DATA_WIDTH{nos[DATA_WIDTH-1]}}, nos} *
                     {{DATA_WIDTH{tos[DATA_WIDTH-1]}}, tos};

    always_comb begin
        result = tos;
        case (op)
            OpAdd:   result = nos + tos;
            OpSub:   result = nos - tos;
            OpMul:   result = DATA_WIDTH'(product >>> FRAC_BITS);
            OpNeg:   result = '0 - tos;
            default: result = tos;
        endcase
    end

endmodule

// File: rtl/stack_machine_core.sv
// RPN execution engine. TOS lives in a register and deeper entries spill to a
// dual-port stack memory (write on port A, registered read on port B).
module stack_machine_core
    import stack_machine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STACK_SIZE = 64,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [2:0]                    instr_opcode,
    input  logic [DATA_WIDTH-1:0]         instr_imm,
    input  logic [DATA_WIDTH-1:0]         x,
    output logic                          result_valid,
    output logic [DATA_WIDTH-1:0]         result,
    output logic                          error,
    output logic [$clog2(STACK_SIZE)-1:0] mem_a_addr,
    output logic                          mem_a_write_enable,
    output logic [DATA_WIDTH-1:0]         mem_a_write_data,
    output logic [$clog2(STACK_SIZE)-1:0] mem_b_addr,
    input  logic [DATA_WIDTH-1:0]         mem_b_read_data
);

    localparam int unsigned AW = $clog2(STACK_SIZE);
    localparam int unsigned DW = AW + 1;
    localparam logic [DW-1:0] DepthFull = DW'(STACK_SIZE);

    state_e                state_q;
    opcode_e               op_q;
    logic [DW-1:0]         depth_q;
    logic [DATA_WIDTH-1:0] tos_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_valid_q;
    logic                  error_q;
    logic [AW-1:0]         b_addr_q;

    opcode_e               opcode;
    opcode_e               alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  accept;
    logic                  idle_err;
    logic                  spill;

    assign opcode      = opcode_e'(instr_opcode);
    assign instr_ready = !rst && ((state_q == StIdle) || (state_q == StError));
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        idle_err = 1'b0;
        case (opcode)
            OpPushImm, OpPushX: idle_err = (depth_q == DepthFull);
            OpAdd, OpSub, OpMul: idle_err = (depth_q < DW'(2));
            OpNeg:              idle_err = (depth_q == '0);
            OpEnd:              idle_err = (depth_q != DW'(1));
            default:            idle_err = 1'b1;
        endcase
    end

    // Old TOS spills to memory in the same cycle the push is accepted.
    assign spill = accept && (state_q == StIdle) && is_push(opcode) && !idle_err &&
                   (depth_q != '0);

    assign mem_a_write_enable = spill;
    assign mem_a_addr         = spill ? AW'(depth_q - DW'(1)) : '0;
    assign mem_a_write_data   = spill ? tos_q : '0;
    assign mem_b_addr         = b_addr_q;

    assign alu_op = (state_q == StExec) ? op_q : OpNeg;

    stack_machine_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_alu (
        .op     (alu_op),
        .nos    (mem_b_read_data),
        .tos    (tos_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= OpAdd;
            depth_q        <= '0;
            tos_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            b_addr_q       <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (idle_err) begin
                            error_q <= 1'b1;
                            state_q <= StError;
                        end else begin
                            case (opcode)
                                OpPushImm: begin
                                    tos_q   <= instr_imm;
                                    depth_q <= depth_q + DW'(1);
                                end
                                OpPushX: begin
                                    tos_q   <= x;
                                    depth_q <= depth_q + DW'(1);
                                end
                                OpAdd, OpSub, OpMul: begin
                                    op_q     <= opcode;
                                    b_addr_q <= AW'(depth_q - DW'(2));
                                    state_q  <= StRead;
                                end
                                OpNeg: tos_q <= alu_result;
                                OpEnd: begin
                                    result_q       <= tos_q;
                                    result_valid_q <= 1'b1;
                                    depth_q        <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                // Memory samples b_addr_q at the end of this cycle.
                StRead: state_q <= StExec;
                StExec: begin
                    tos_q   <= alu_result;
                    depth_q <= depth_q - DW'(1);
                    state_q <= StIdle;
                end
                StError: begin
                    if (accept && (opcode == OpEnd)) begin
                        error_q <= 1'b0;
                        depth_q <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;

endmodule

// File: tb/tb_stack_machine_core.sv
// Self-checking bench for stack_machine_core: directed scenarios plus random
// programs evaluated by a queue-based RPN reference model.
module tb_stack_machine_core;

    localparam int W = 16;
    localparam int FRAC = 8;

    localparam logic [2:0] PUSH_IMM = 3'd0, PUSH_X = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           MUL = 3'd4, NEG = 3'd5, END_OP = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance, STACK_SIZE=64
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [2:0]   instr_opcode = '0;
    logic [W-1:0] instr_imm = '0;
    logic [W-1:0] x_in = '0;
    logic         result_valid;
    logic [W-1:0] result;
    logic         error;
    logic [5:0]   a_addr, b_addr;
    logic         a_we;
    logic [W-1:0] a_data, b_data;

    // Small instance, STACK_SIZE=4
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [2:0]   s_opcode = '0;
    logic [W-1:0] s_imm = '0;
    logic         s_result_valid;
    logic [W-1:0] s_result;
    logic         s_error;
    logic [1:0]   s_a_addr, s_b_addr;
    logic         s_a_we;
    logic [W-1:0] s_a_data, s_b_data;

    stack_machine_core #(.DATA_WIDTH(W), .STACK_SIZE(64), .FRAC_BITS(FRAC)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_imm(instr_imm), .x(x_in),
        .result_valid(result_valid), .result(result), .error(error),
        .mem_a_addr(a_addr), .mem_a_write_enable(a_we), .mem_a_write_data(a_data),
        .mem_b_addr(b_addr), .mem_b_read_data(b_data)
    );

    stack_machine_core #(.DATA_WIDTH(W), .STACK_SIZE(4), .FRAC_BITS(FRAC)) dut_small (
        .clk(clk), .rst(rst), .instr_valid(s_valid), .instr_ready(s_ready),
        .instr_opcode(s_opcode), .instr_imm(s_imm), .x(x_in),
        .result_valid(s_result_valid), .result(s_result), .error(s_error),
        .mem_a_addr(s_a_addr), .mem_a_write_enable(s_a_we), .mem_a_write_data(s_a_data),
        .mem_b_addr(s_b_addr), .mem_b_read_data(s_b_data)
    );

    // Stack memory models with 1-cycle registered read
    logic [W-1:0] mem [64];
    logic [W-1:0] s_mem [4];
    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_data;
        b_data <= mem[b_addr];
        if (s_a_we) s_mem[s_a_addr] <= s_a_data;
        s_b_data <= s_mem[s_b_addr];
    end

    // Monitors, sampled on the falling edge
    int           rv_count = 0;
    logic [W-1:0] last_result = '0;
    int           wr_addr_q[$];
    logic [W-1:0] wr_data_q[$];
    int           s_wr_addr_q[$];
    always @(negedge clk) begin
        if (result_valid) begin
            rv_count <= rv_count + 1;
            last_result <= result;
        end
        if (a_we) begin
            wr_addr_q.push_back(int'(a_addr));
            wr_data_q.push_back(a_data);
        end
        if (s_a_we) s_wr_addr_q.push_back(int'(s_a_addr));
    end

    int tests = 0;
    int fails = 0;

    task automatic issue(input logic [2:0] op, input logic [W-1:0] imm, input logic [W-1:0] xv);
        int n = 0;
        instr_valid = 1'b1;
        instr_opcode = op;
        instr_imm = imm;
        x_in = xv;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: instr_ready stayed %b, required 1", instr_ready);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic issue_s(input logic [2:0] op, input logic [W-1:0] imm);
        s_valid = 1'b1;
        s_opcode = op;
        s_imm = imm;
        @(negedge clk);
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL small_ready: got %b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Reference semantics: a = next-of-stack, b = top-of-stack
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint p;
        case (op)
            ADD: return a + b;
            SUB: return a - b;
            MUL: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return W'(p >>> FRAC);
            end
            NEG: return W'(0) - b;
            default: return b;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", instr_ready); end
        tests++; if (result !== '0) begin fails++; $display("FAIL reset_result: got %h required 0000", result); end
        tests++; if (result_valid !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_flags: got rv=%b err=%b required 0 0", result_valid, error); end
        tests++; if (a_we !== 1'b0 || a_addr !== '0 || b_addr !== '0) begin fails++; $display("FAIL reset_mem: got we=%b a=%0d b=%0d required 0 0 0", a_we, a_addr, b_addr); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (instr_ready !== 1'b1 || s_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b/%b required 1/1", instr_ready, s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int base;
        int lows = 0;
        issue(PUSH_IMM, 16'h0180, '0);
        issue(PUSH_IMM, 16'h0200, '0);
        issue(MUL, '0, '0);
        @(negedge clk);
        while (!instr_ready && lows < 10) begin
            lows++;
            @(negedge clk);
        end
        tests++; if (lows != 2) begin fails++; $display("FAIL mul_ready_low: got %0d cycles required 2", lows); end
        @(posedge clk); #1;
        base = rv_count;
        issue(END_OP, '0, '0);
        repeat (3) @(negedge clk);
        tests++; if (last_result !== 16'h0300) begin fails++; $display("FAIL mul_result: got %h required 0300", last_result); end
        tests++; if (rv_count != base + 1) begin fails++; $display("FAIL mul_rv_pulses: got %0d required 1", rv_count - base); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_neg();
        wr_addr_q.delete();
        wr_data_q.delete();
        issue(PUSH_X, '0, 16'h0100);
        issue(PUSH_IMM, 16'h0300, '0);
        issue(SUB, '0, '0);
        issue(NEG, '0, '0);
        issue(END_OP, '0, '0);
        repeat (2) @(negedge clk);
        tests++; if (last_result !== 16'h0200) begin fails++; $display("FAIL subneg_result: got %h required 0200", last_result); end
        tests++; if (wr_addr_q.size() != 1) begin fails++; $display("FAIL subneg_write_count: got %0d required 1", wr_addr_q.size()); end
        else begin
            tests++; if (wr_addr_q[0] != 0 || wr_data_q[0] !== 16'h0100) begin fails++; $display("FAIL subneg_write: got addr %0d data %h required 0 0100", wr_addr_q[0], wr_data_q[0]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        issue(PUSH_IMM, 16'h7FFF, '0);
        issue(PUSH_IMM, 16'h0001, '0);
        issue(ADD, '0, '0);
        issue(END_OP, '0, '0);
        repeat (2) @(negedge clk);
        tests++; if (last_result !== 16'h8000) begin fails++; $display("FAIL add_wrap: got %h required 8000", last_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        int base = rv_count;
        wr_addr_q.delete();
        issue(PUSH_IMM, 16'h0005, '0);
        issue(ADD, '0, '0);
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL underflow_error: got %b required 1", error); end
        issue(PUSH_IMM, 16'h0009, '0);
        issue(PUSH_IMM, 16'h000A, '0);
        @(negedge clk);
        tests++; if (error !== 1'b1 || instr_ready !== 1'b1) begin fails++; $display("FAIL error_discard: got err=%b ready=%b required 1 1", error, instr_ready); end
        tests++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL error_no_write: got %0d writes required 0", wr_addr_q.size()); end
        @(posedge clk); #1;
        issue(END_OP, '0, '0);
        @(negedge clk);
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL error_clear: got %b required 0", error); end
        tests++; if (rv_count != base) begin fails++; $display("FAIL error_no_rv: got %0d pulses required 0", rv_count - base); end
        @(posedge clk); #1;
        issue(PUSH_IMM, 16'h0003, '0);
        issue(PUSH_IMM, 16'h0004, '0);
        issue(ADD, '0, '0);
        issue(END_OP, '0, '0);
        repeat (2) @(negedge clk);
        tests++; if (last_result !== 16'h0007 || rv_count != base + 1) begin fails++; $display("FAIL after_error_program: got %h (%0d pulses) required 0007 (1)", last_result, rv_count - base); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        s_wr_addr_q.delete();
        for (int i = 0; i < 5; i++) begin
            issue_s(PUSH_IMM, W'(i + 1));
            tests++;
            if (s_error !== (i == 4)) begin
                fails++;
                $display("FAIL overflow_push%0d: got err=%b required %b", i, s_error, i == 4);
            end
        end
        @(negedge clk);
        tests++; if (s_wr_addr_q.size() != 3) begin fails++; $display("FAIL overflow_writes: got %0d required 3", s_wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (s_wr_addr_q[i] != i) begin fails++; $display("FAIL overflow_addr%0d: got %0d required %0d", i, s_wr_addr_q[i], i); end
            end
        end
        @(posedge clk); #1;
        issue_s(END_OP, '0);
        tests++; if (s_error !== 1'b0) begin fails++; $display("FAIL overflow_clear: got %b required 0", s_error); end
    endtask

    task automatic test_async_reset();
        int base;
        issue(PUSH_IMM, 16'h0100, '0);
        issue(PUSH_IMM, 16'h0200, '0);
        issue(PUSH_IMM, 16'h0300, '0);
        issue(MUL, '0, '0);
        tests++; if (b_addr !== 6'd1 || instr_ready !== 1'b0) begin fails++; $display("FAIL mul_read_state: got b_addr=%0d ready=%b required 1 0", b_addr, instr_ready); end
        #2 rst = 1'b1;
        #1;
        tests++; if (b_addr !== '0 || instr_ready !== 1'b0) begin fails++; $display("FAIL async_reset_ctrl: got b_addr=%0d ready=%b required 0 0", b_addr, instr_ready); end
        tests++; if (result !== '0 || error !== 1'b0 || result_valid !== 1'b0 || a_we !== 1'b0) begin fails++; $display("FAIL async_reset_out: got res=%h err=%b rv=%b we=%b required 0", result, error, result_valid, a_we); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        base = rv_count;
        issue(PUSH_IMM, 16'h0005, '0);
        issue(END_OP, '0, '0);
        repeat (2) @(negedge clk);
        tests++; if (last_result !== 16'h0005 || rv_count != base + 1) begin fails++; $display("FAIL post_reset_program: got %h (%0d pulses) required 0005 (1)", last_result, rv_count - base); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int p = 0; p < 30; p++) begin
            logic [W-1:0] st[$];
            logic [W-1:0] a, b, v;
            logic [2:0] op;
            int nops = int'($urandom_range(1, 12));
            int base = rv_count;
            int k = 0;
            while (k < nops || st.size() != 1) begin
                if (st.size() == 0 || (st.size() == 1 && k < nops && $urandom_range(0, 3) != 0))
                    op = ($urandom_range(0, 1) == 0) ? PUSH_IMM : PUSH_X;
                else if (st.size() == 1)
                    op = NEG;
                else if (k < nops && st.size() < 8)
                    op = 3'($urandom_range(0, 5));
                else
                    op = 3'($urandom_range(2, 4));
                v = W'($urandom());
                case (op)
                    PUSH_IMM: begin issue(op, v, W'($urandom())); st.push_back(v); end
                    PUSH_X:   begin issue(op, W'($urandom()), v); st.push_back(v); end
                    NEG: begin
                        issue(op, '0, '0);
                        b = st.pop_back();
                        st.push_back(ref_op(NEG, '0, b));
                    end
                    default: begin
                        issue(op, '0, '0);
                        b = st.pop_back();
                        a = st.pop_back();
                        st.push_back(ref_op(op, a, b));
                    end
                endcase
                k++;
            end
            issue(END_OP, '0, '0);
            repeat (2) @(negedge clk);
            tests++;
            if (last_result !== st[0] || rv_count != base + 1 || error !== 1'b0) begin
                fails++;
                $display("FAIL random_prog%0d: got %h (%0d pulses, err=%b) required %h (1, 0)",
                         p, last_result, rv_count - base, error, st[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_sub_neg();
        test_wrap();
        test_error();
        test_overflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
